// File: rtl/counter_run_arbiter.sv
// Round-robin owner of a shared counter datapath: grants one requester at a time,
// clears the counter, enables it for the latched run length, then pulses done.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no owner; counter held in clear; arbitrate among active requests
// CLEAR | owner granted; counter cleared this cycle
// RUN   | counter enabled; leaves when the final increment lands
// DONE  | done pulse to owner; counter holds the completed run count
module counter_run_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   len,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic                    busy,
  output logic                    ctr_rst,
  output logic                    ctr_en,
  input  logic [WIDTH-1:0]        ctr_count
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    owner, owner_nxt;
  logic [IW-1:0]    last, last_nxt;
  logic [WIDTH-1:0] len_q, len_nxt;
  logic [IW-1:0]    pick;
  logic             pick_vld;
  logic             owner_req;
  logic             run_last;
  int               rr_idx;

  // Search starts one past the previous owner, so it ends up lowest priority.
  always_comb begin
    pick     = last;
    pick_vld = 1'b0;
    rr_idx   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      rr_idx = (int'(last) + i) % NREQ;
      if (!pick_vld && req[rr_idx]) begin
        pick     = IW'(rr_idx);
        pick_vld = 1'b1;
      end
    end
  end

  assign owner_req = req[owner];
  assign run_last  = (ctr_count == (len_q - WIDTH'(1)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      owner <= '0;
      last  <= IW'(NREQ - 1);
      len_q <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
      len_q <= len_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    len_nxt   = len_q;
    case (state)
      S_IDLE: begin
        if (pick_vld) begin
          owner_nxt = pick;
          len_nxt   = len[pick*WIDTH +: WIDTH];
          state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (!owner_req) begin
          last_nxt  = owner;
          state_nxt = S_IDLE;
        end else if (len_q != '0) begin
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_DONE;
        end
      end
      S_RUN: begin
        // Withdrawal wins over completion: an aborted run never reports done.
        if (!owner_req) begin
          last_nxt  = owner;
          state_nxt = S_IDLE;
        end else if (run_last) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        last_nxt  = owner;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    gnt     = '0;
    done    = '0;
    ctr_rst = 1'b1;
    ctr_en  = 1'b0;
    case (state)
      S_CLEAR: begin
        gnt[owner] = 1'b1;
      end
      S_RUN: begin
        gnt[owner] = 1'b1;
        ctr_rst    = 1'b0;
        ctr_en     = 1'b1;
      end
      S_DONE: begin
        gnt[owner]  = 1'b1;
        done[owner] = 1'b1;
        ctr_rst     = 1'b0;
      end
      default: begin
        gnt     = '0;
        ctr_rst = 1'b1;
      end
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_counter_run_arbiter.sv
// Directed bench for counter_run_arbiter with a behavioural model of the shared counter.
module tb_counter_run_arbiter;
  localparam int WIDTH = 8;
  localparam int NREQ  = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] len = '0;
  logic [NREQ-1:0]       gnt, done;
  logic                  busy, ctr_rst, ctr_en;
  logic [WIDTH-1:0]      ctr_count;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ctr_rst)     ctr_count <= '0;
    else if (ctr_en) ctr_count <= ctr_count + 1'b1;
  end

  counter_run_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req(req), .len(len), .gnt(gnt), .done(done),
    .busy(busy), .ctr_rst(ctr_rst), .ctr_en(ctr_en), .ctr_count(ctr_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, want);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int gc, ec, dc, cnt, r;
    logic [NREQ-1:0] eg;

    // reset state
    #1 rst = 1'b0;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ctr_rst", ctr_rst, 1);
    chk("rst_ctr_en", ctr_en, 0);
    cyc(); cyc();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk($sformatf("idle%0d_gnt", i), gnt, 0);
      chk($sformatf("idle%0d_busy", i), busy, 0);
      chk($sformatf("idle%0d_ctr_rst", i), ctr_rst, 1);
      chk($sformatf("idle%0d_ctr_en", i), ctr_en, 0);
    end

    // single request, requester 2, len 5
    len[2*WIDTH +: WIDTH] = 8'd5;
    req = 4'b0100;
    cyc();
    chk("single_first_gnt", gnt, 4'b0100);
    chk("single_first_busy", busy, 1);
    chk("single_first_ctr_rst", ctr_rst, 1);
    gc = 0; ec = 0; dc = 0; cnt = -1;
    for (int i = 0; i < 12; i++) begin
      if (gnt == 4'b0100) gc++;
      if (ctr_en) ec++;
      if (done != '0) begin
        dc++;
        chk("single_done_idx", done, 4'b0100);
        cnt = int'(ctr_count);
        req = '0;
      end
      cyc();
    end
    chk("single_gnt_cycles", gc, 7);
    chk("single_en_cycles", ec, 5);
    chk("single_done_pulses", dc, 1);
    chk("single_count_at_done", cnt, 5);

    // reset, then all four held: order 0,1,2,3,0 with one idle cycle between runs
    rst = 1'b0;
    #1;
    chk("rr_rst_gnt", gnt, 0);
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) len[i*WIDTH +: WIDTH] = 8'd3;
    req = 4'b1111;
    for (int k = 1; k <= 29; k++) begin
      cyc();
      r  = (k - 1) % 6;
      eg = (r == 5) ? 4'b0000 : 4'(1 << (((k - 1) / 6) % 4));
      chk($sformatf("rr%0d_gnt", k), gnt, eg);
      chk($sformatf("rr%0d_ctr_en", k), ctr_en, (r >= 1 && r <= 3) ? 1 : 0);
      chk($sformatf("rr%0d_done", k), done, (r == 4) ? eg : 4'b0000);
      if (r == 4) chk($sformatf("rr%0d_count", k), ctr_count, 3);
    end
    req = '0;
    cyc();
    chk("rr_end_gnt", gnt, 0);

    // zero-length run on requester 1
    len[1*WIDTH +: WIDTH] = 8'd0;
    req = 4'b0010;
    cyc();
    chk("zero_clear_gnt", gnt, 4'b0010);
    chk("zero_clear_en", ctr_en, 0);
    chk("zero_clear_done", done, 0);
    cyc();
    chk("zero_done_gnt", gnt, 4'b0010);
    chk("zero_done_done", done, 4'b0010);
    chk("zero_done_en", ctr_en, 0);
    req = '0;
    cyc();
    chk("zero_after_gnt", gnt, 0);
    chk("zero_after_done", done, 0);

    // abort requester 0 in its second RUN cycle; pending requester 1 follows
    len[0 +: WIDTH]     = 8'd10;
    len[WIDTH +: WIDTH] = 8'd2;
    req = 4'b0011;
    cyc();
    chk("abort_clear_gnt", gnt, 4'b0001);
    cyc();
    chk("abort_run1_en", ctr_en, 1);
    chk("abort_run1_count", ctr_count, 0);
    cyc();
    chk("abort_run2_en", ctr_en, 1);
    chk("abort_run2_count", ctr_count, 1);
    chk("abort_run2_done", done, 0);
    req[0] = 1'b0;
    cyc();
    chk("abort_gnt", gnt, 0);
    chk("abort_ctr_rst", ctr_rst, 1);
    chk("abort_ctr_en", ctr_en, 0);
    chk("abort_done", done, 0);
    cyc();
    chk("abort_next_gnt", gnt, 4'b0010);
    cyc(); cyc(); cyc();
    chk("abort_next_done", done, 4'b0010);
    chk("abort_next_count", ctr_count, 2);
    req = '0;
    cyc();

    // reset in the middle of a long run
    len[0 +: WIDTH] = 8'd200;
    req = 4'b0001;
    cyc();
    chk("midrst_clear_gnt", gnt, 4'b0001);
    repeat (6) cyc();
    chk("midrst_run_en", ctr_en, 1);
    chk("midrst_run_count", ctr_count, 5);
    rst = 1'b0;
    #1;
    chk("midrst_gnt", gnt, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_ctr_rst", ctr_rst, 1);
    chk("midrst_ctr_en", ctr_en, 0);
    req = 4'b1111;
    cyc();
    chk("midrst_held_gnt", gnt, 0);
    rst = 1'b1;
    cyc();
    chk("midrst_first_owner", gnt, 4'b0001);
    req = '0;
    cyc();
    chk("midrst_withdrawn_gnt", gnt, 0);

    // maximum run length on requester 3
    len[3*WIDTH +: WIDTH] = 8'd255;
    req = 4'b1000;
    gc = 0; dc = 0; cnt = -1;
    for (int i = 0; i < 300 && dc == 0; i++) begin
      cyc();
      if (gnt == 4'b1000) gc++;
      if (done != '0) begin
        dc++;
        cnt = int'(ctr_count);
        req = '0;
      end
    end
    chk("max_gnt_cycles", gc, 257);
    chk("max_done_pulses", dc, 1);
    chk("max_count_at_done", cnt, 255);
    cyc();
    chk("max_after_gnt", gnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
